// File: rtl/i2s_pkg.sv
// Shared types and default geometry for the I2S receive controller.
package i2s_pkg;

    localparam int I2S_SAMPLE_W      = 24;
    localparam int I2S_SLOT_W        = 32;
    localparam int I2S_WARMUP_FRAMES = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } i2s_rx_state_t;

endpackage

// File: rtl/i2s_rx_ctrl_if.sv
// Control, serial and sample-handshake signals of the I2S receive controller.
interface i2s_rx_ctrl_if #(
    parameter int SAMPLE_W = i2s_pkg::I2S_SAMPLE_W
);
    logic                enable;
    logic                sd_in;
    logic                ws_out;
    logic [SAMPLE_W-1:0] sample_data;
    logic                sample_is_right;
    logic                sample_valid;
    logic                sample_ready;
    logic                overflow;
    logic                clr_overflow;
    logic                busy;

    // master is the receive controller, slave is the mic/pipeline side
    modport master (
        input  enable, sd_in, sample_ready, clr_overflow,
        output ws_out, sample_data, sample_is_right, sample_valid, overflow, busy
    );

    modport slave (
        output enable, sd_in, sample_ready, clr_overflow,
        input  ws_out, sample_data, sample_is_right, sample_valid, overflow, busy
    );
endinterface

// File: rtl/i2s_deser.sv
// MSB-first deserialiser: shifts sd_in during slot bits 1..SAMPLE_W and flags the last bit.
module i2s_deser #(
    parameter int SAMPLE_W = 24,
    parameter int CNT_W    = 5
) (
    input  logic                sclk,
    input  logic                reset,
    input  logic                i_capture_en,
    input  logic [CNT_W-1:0]    i_cnt,
    input  logic                i_sd,
    output logic [SAMPLE_W-1:0] o_word,
    output logic                o_word_done
);

    // Only SAMPLE_W-1 bits are stored; the final bit joins combinationally so the
    // word is ready in the same cycle it completes.
    logic [SAMPLE_W-2:0] r_shift;
    logic [SAMPLE_W-1:0] w_shift_next;
    logic                w_in_window;

    assign w_shift_next = {r_shift, i_sd};
    assign w_in_window  = i_capture_en
                        && (i_cnt >= CNT_W'(1))
                        && (i_cnt <= CNT_W'(SAMPLE_W));

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
        end else if (w_in_window) begin
            r_shift <= w_shift_next[SAMPLE_W-2:0];
        end
    end

    assign o_word      = w_shift_next;
    assign o_word_done = i_capture_en && (i_cnt == CNT_W'(SAMPLE_W));

endmodule

// File: rtl/i2s_rx_ctrl.sv
// I2S receive controller: word-select generation, warm-up sequencing, capture and
// a single-entry valid/ready output stage with sticky overflow.
module i2s_rx_ctrl
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W      = I2S_SAMPLE_W,
    parameter int SLOT_W        = I2S_SLOT_W,
    parameter int WARMUP_FRAMES = I2S_WARMUP_FRAMES
) (
    input  logic          sclk,
    input  logic          reset,
    i2s_rx_ctrl_if.master bus
);

    localparam int CNT_W = $clog2(SLOT_W);
    localparam int FRM_W = $clog2(WARMUP_FRAMES + 1);

    i2s_rx_state_t       r_state;
    i2s_rx_state_t       w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ws;
    logic [FRM_W-1:0]    r_frm;
    logic [SAMPLE_W-1:0] r_data;
    logic                r_is_right;
    logic                r_valid;
    logic                r_overflow;

    logic                w_slot_end;
    logic                w_frame_end;
    logic                w_warmup_done;
    logic [SAMPLE_W-1:0] w_word;
    logic                w_word_done;
    logic                w_accept;
    logic                w_drop;

    assign w_slot_end    = (r_cnt == CNT_W'(SLOT_W - 1));
    assign w_frame_end   = w_slot_end && r_ws;
    assign w_warmup_done = (r_frm == FRM_W'(WARMUP_FRAMES - 1));

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // enable is only examined at the end of a right slot, so dropping it and
    // raising it again before then simply never stops the interface.
    // NOTE: the default assignment first keeps this combinational block latch-free.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.enable) begin
                    w_state_next = WARMUP;
                end
            end
            WARMUP: begin
                if (w_frame_end) begin
                    if (!bus.enable) begin
                        w_state_next = IDLE;
                    end else if (w_warmup_done) begin
                        w_state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (w_frame_end && !bus.enable) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Slot counter and word select; both sit at zero while idle so a restart
    // always begins with cnt=0 of a left slot.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_ws  <= 1'b0;
        end else if (r_state == IDLE) begin
            r_cnt <= '0;
            r_ws  <= 1'b0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_ws  <= ~r_ws;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            r_frm <= '0;
        end else if (r_state != WARMUP) begin
            r_frm <= '0;
        end else if (w_frame_end && !w_warmup_done) begin
            r_frm <= r_frm + FRM_W'(1);
        end
    end

    i2s_deser #(
        .SAMPLE_W (SAMPLE_W),
        .CNT_W    (CNT_W)
    ) u_deser (
        .sclk         (sclk),
        .reset        (reset),
        .i_capture_en (r_state == RUN),
        .i_cnt        (r_cnt),
        .i_sd         (bus.sd_in),
        .o_word       (w_word),
        .o_word_done  (w_word_done)
    );

    // A word arriving while the held one is being accepted replaces it with no bubble.
    assign w_accept = r_valid && bus.sample_ready;
    assign w_drop   = w_word_done && r_valid && !bus.sample_ready;

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            r_data     <= '0;
            r_is_right <= 1'b0;
            r_valid    <= 1'b0;
        end else if (w_word_done && (!r_valid || w_accept)) begin
            r_data     <= w_word;
            r_is_right <= r_ws;
            r_valid    <= 1'b1;
        end else if (w_accept) begin
            r_valid    <= 1'b0;
        end
    end

    // A drop in the same cycle as a clear request leaves the flag set.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.ws_out          = r_ws;
    assign bus.sample_data     = r_data;
    assign bus.sample_is_right = r_is_right;
    assign bus.sample_valid    = r_valid;
    assign bus.overflow        = r_overflow;
    assign bus.busy            = (r_state != IDLE);

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Directed bench for i2s_rx_ctrl with a falling-edge I2S microphone model.
module tb_i2s_rx_ctrl;
    import i2s_pkg::*;

    localparam int SW = 24;
    localparam int SL = 32;
    localparam int WF = 2;

    typedef struct {
        logic [SW-1:0] left;
        logic [SW-1:0] right;
        logic          junk;
        logic [SW-1:0] exp_left;
        logic [SW-1:0] exp_right;
    } vec_t;

    logic sclk = 1'b0;
    logic reset;

    i2s_rx_ctrl_if #(.SAMPLE_W(SW)) bus ();

    i2s_rx_ctrl #(
        .SAMPLE_W      (SW),
        .SLOT_W        (SL),
        .WARMUP_FRAMES (WF)
    ) dut (
        .sclk  (sclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 sclk = ~sclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Mic model: bit k of a slot (k=1..SW) carries word bit SW-k; other bits carry mic_junk.
    logic [SW-1:0] mic_l    = '0;
    logic [SW-1:0] mic_r    = '0;
    logic          mic_junk = 1'b0;
    logic          mic_last_ws = 1'b0;
    int            mic_pos  = 0;

    always @(negedge sclk) begin
        logic [SW-1:0] w;
        if (bus.ws_out !== mic_last_ws) mic_pos = 0;
        else if (mic_pos < 1000) mic_pos++;
        mic_last_ws = bus.ws_out;
        w = bus.ws_out ? mic_r : mic_l;
        if (mic_pos >= 1 && mic_pos <= SW) bus.sd_in = w[SW-mic_pos];
        else bus.sd_in = mic_junk;
    end

    // Returns at the falling edge of the next cycle with sample_valid high.
    task automatic wait_valid(input string name, output logic [SW-1:0] d, output logic r);
        int n;
        n = 0;
        @(negedge sclk);
        while (bus.sample_valid !== 1'b1 && n < 200) begin
            @(negedge sclk);
            n++;
        end
        if (bus.sample_valid !== 1'b1) check({name, "_timeout"}, {31'd0, bus.sample_valid}, 32'd1);
        d = bus.sample_data;
        r = bus.sample_is_right;
    endtask

    vec_t          vecs [5];
    logic [SW-1:0] d;
    logic          r;
    logic [SW-1:0] exp_w;

    initial begin
        vecs[0] = '{24'hA5A5A5, 24'h5A5A5A, 1'b0, 24'hA5A5A5, 24'h5A5A5A};
        vecs[1] = '{24'hFFFFFF, 24'h000000, 1'b1, 24'hFFFFFF, 24'h000000};
        vecs[2] = '{24'h800001, 24'h000001, 1'b1, 24'h800001, 24'h000001};
        vecs[3] = '{24'h123456, 24'hFEDCBA, 1'b0, 24'h123456, 24'hFEDCBA};
        vecs[4] = '{24'h000000, 24'hFFFFFF, 1'b1, 24'h000000, 24'hFFFFFF};

        reset            = 1'b1;
        bus.enable       = 1'b0;
        bus.sample_ready = 1'b1;
        bus.clr_overflow = 1'b0;
        mic_l = 24'hA5A5A5;
        mic_r = 24'h5A5A5A;
        repeat (3) @(negedge sclk);
        check("rst_valid", {31'd0, bus.sample_valid}, 32'd0);
        check("rst_data",  {8'd0, bus.sample_data}, 32'd0);
        check("rst_busy",  {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;
        @(negedge sclk);
        check("idle_ws",   {31'd0, bus.ws_out}, 32'd0);
        check("idle_tag",  {31'd0, bus.sample_is_right}, 32'd0);
        check("idle_ovf",  {31'd0, bus.overflow}, 32'd0);

        // Start-up timing: cycle 0 is the first WARMUP cycle.
        bus.enable = 1'b1;
        @(posedge sclk);
        for (int c = 0; c < 190; c++) begin
            @(negedge sclk);
            if (c % 16 == 0 || c == 31 || c == 32) check("ws_timing", {31'd0, bus.ws_out}, 32'((c / 32) % 2));
            if (c % 16 == 0 || c == 152) begin
                if (c < 153) check("no_early_valid", {31'd0, bus.sample_valid}, 32'd0);
            end
            if (c == 0) check("busy_run", {31'd0, bus.busy}, 32'd1);
            if (c == 153) begin
                check("first_valid", {31'd0, bus.sample_valid}, 32'd1);
                check("first_data",  {8'd0, bus.sample_data}, 32'hA5A5A5);
                check("first_tag",   {31'd0, bus.sample_is_right}, 32'd0);
            end
            if (c == 154) check("valid_drops", {31'd0, bus.sample_valid}, 32'd0);
            if (c == 185) begin
                check("second_valid", {31'd0, bus.sample_valid}, 32'd1);
                check("second_data",  {8'd0, bus.sample_data}, 32'h5A5A5A);
                check("second_tag",   {31'd0, bus.sample_is_right}, 32'd1);
            end
        end

        // Table of patterns, including junk outside the capture window.
        for (int i = 0; i < 5; i++) begin
            mic_l    = vecs[i].left;
            mic_r    = vecs[i].right;
            mic_junk = vecs[i].junk;
            wait_valid("vec_left", d, r);
            check("vec_left_data", {8'd0, d}, {8'd0, vecs[i].exp_left});
            check("vec_left_tag",  {31'd0, r}, 32'd0);
            wait_valid("vec_right", d, r);
            check("vec_right_data", {8'd0, d}, {8'd0, vecs[i].exp_right});
            check("vec_right_tag",  {31'd0, r}, 32'd1);
        end
        mic_junk = 1'b0;

        // Eight frames of an incrementing pattern with ready held high.
        for (int f = 0; f < 8; f++) begin
            mic_l = 24'h100000 + 24'(2 * f);
            mic_r = 24'h100000 + 24'(2 * f + 1);
            for (int s = 0; s < 2; s++) begin
                exp_w = 24'h100000 + 24'(2 * f + s);
                wait_valid("incr", d, r);
                check("incr_data", {8'd0, d}, {8'd0, exp_w});
                check("incr_tag",  {31'd0, r}, 32'(s));
            end
        end
        check("incr_ovf", {31'd0, bus.overflow}, 32'd0);

        // ready pulsed exactly when the next word completes.
        @(negedge sclk);
        bus.sample_ready = 1'b0;
        mic_l = 24'h0F0F0F;
        mic_r = 24'hC3C3C3;
        wait_valid("pulse_left", d, r);
        check("pulse_left_data", {8'd0, d}, 32'h0F0F0F);
        repeat (31) @(negedge sclk);
        check("pulse_held", {8'd0, bus.sample_data}, 32'h0F0F0F);
        bus.sample_ready = 1'b1;
        @(negedge sclk);
        check("pulse_valid", {31'd0, bus.sample_valid}, 32'd1);
        check("pulse_new_data", {8'd0, bus.sample_data}, 32'hC3C3C3);
        check("pulse_new_tag", {31'd0, bus.sample_is_right}, 32'd1);
        check("pulse_ovf", {31'd0, bus.overflow}, 32'd0);
        @(negedge sclk);
        check("pulse_drained", {31'd0, bus.sample_valid}, 32'd0);

        // Back-pressure: left held, right dropped, overflow clear and set-wins.
        bus.sample_ready = 1'b0;
        mic_l = 24'h111111;
        mic_r = 24'h222222;
        wait_valid("bp_left", d, r);
        check("bp_left_data", {8'd0, d}, 32'h111111);
        repeat (16) @(negedge sclk);
        check("bp_hold_mid", {8'd0, bus.sample_data}, 32'h111111);
        check("bp_no_ovf_yet", {31'd0, bus.overflow}, 32'd0);
        repeat (16) @(negedge sclk);
        check("bp_ovf_set", {31'd0, bus.overflow}, 32'd1);
        check("bp_hold_after_drop", {8'd0, bus.sample_data}, 32'h111111);
        check("bp_hold_tag", {31'd0, bus.sample_is_right}, 32'd0);
        @(negedge sclk);
        bus.clr_overflow = 1'b1;
        @(negedge sclk);
        bus.clr_overflow = 1'b0;
        check("bp_ovf_cleared", {31'd0, bus.overflow}, 32'd0);
        check("bp_still_valid", {31'd0, bus.sample_valid}, 32'd1);
        repeat (29) @(negedge sclk);
        bus.clr_overflow = 1'b1;
        @(negedge sclk);
        bus.clr_overflow = 1'b0;
        check("bp_set_wins", {31'd0, bus.overflow}, 32'd1);
        check("bp_hold_late", {8'd0, bus.sample_data}, 32'h111111);
        @(negedge sclk);
        bus.clr_overflow = 1'b1;
        @(negedge sclk);
        bus.clr_overflow = 1'b0;
        check("bp_ovf_cleared2", {31'd0, bus.overflow}, 32'd0);
        bus.sample_ready = 1'b1;
        @(negedge sclk);
        check("bp_drained", {31'd0, bus.sample_valid}, 32'd0);

        // Stop request at cnt=5 of a left slot.
        wait_valid("stop_sync", d, r);
        check("stop_sync_data", {8'd0, d}, 32'h222222);
        check("stop_sync_tag", {31'd0, r}, 32'd1);
        mic_l = 24'h333333;
        mic_r = 24'h444444;
        repeat (12) @(negedge sclk);
        check("stop_left_slot", {31'd0, bus.ws_out}, 32'd0);
        bus.enable = 1'b0;
        wait_valid("stop_left", d, r);
        check("stop_left_data", {8'd0, d}, 32'h333333);
        wait_valid("stop_right", d, r);
        check("stop_right_data", {8'd0, d}, 32'h444444);
        check("stop_right_tag", {31'd0, r}, 32'd1);
        repeat (6) @(negedge sclk);
        check("stop_busy_last", {31'd0, bus.busy}, 32'd1);
        check("stop_ws_last", {31'd0, bus.ws_out}, 32'd1);
        @(negedge sclk);
        check("stop_busy_fall", {31'd0, bus.busy}, 32'd0);
        check("stop_ws_idle", {31'd0, bus.ws_out}, 32'd0);
        repeat (40) @(negedge sclk);
        check("stop_quiet_valid", {31'd0, bus.sample_valid}, 32'd0);
        check("stop_quiet_busy", {31'd0, bus.busy}, 32'd0);

        // Asynchronous reset mid-RUN with a held word and overflow set.
        bus.sample_ready = 1'b0;
        mic_l = 24'h555555;
        mic_r = 24'h666666;
        bus.enable = 1'b1;
        wait_valid("rr_left", d, r);
        check("rr_left_data", {8'd0, d}, 32'h555555);
        repeat (40) @(negedge sclk);
        check("rr_pre_ovf", {31'd0, bus.overflow}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rr_valid", {31'd0, bus.sample_valid}, 32'd0);
        check("rr_data", {8'd0, bus.sample_data}, 32'd0);
        check("rr_tag", {31'd0, bus.sample_is_right}, 32'd0);
        check("rr_ovf", {31'd0, bus.overflow}, 32'd0);
        check("rr_busy", {31'd0, bus.busy}, 32'd0);
        check("rr_ws", {31'd0, bus.ws_out}, 32'd0);
        bus.enable = 1'b0;
        @(negedge sclk);
        reset = 1'b0;
        repeat (3) @(negedge sclk);
        check("rr_idle_busy", {31'd0, bus.busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
